// File: rtl/se_pkg.sv
// Shared types and constants for the squeeze-and-excitation frame sequencer.
package se_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W1,
        LOAD_W2,
        SQUEEZE,
        WAIT_ATT,
        EXCITE
    } se_state_t;

    // Unity gain in Q8.8
    localparam logic [15:0] SCALE_ONE = 16'h0100;

    // Words in one 1x1 kernel (conv1 and conv2 are the same size)
    function automatic int unsigned calc_k1(input int unsigned channels,
                                            input int unsigned reduction);
        return (channels * channels) / reduction;
    endfunction

    // Words in one frame
    function automatic int unsigned calc_total(input int unsigned height,
                                               input int unsigned width,
                                               input int unsigned channels);
        return height * width * channels;
    endfunction

endpackage

// File: rtl/se_scale_table.sv
// Per-channel attention scale store: one synchronous write, one combinational read.
module se_scale_table
    import se_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Unity scale after reset so an unwritten channel passes data unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= DATA_WIDTH'(SCALE_ONE);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/se_frame_sequencer.sv
// Frame controller for the SE datapath: kernel load, squeeze, attention capture
// and buffered replay with a per-channel scale aligned to each buffer word.
module se_frame_sequencer
    import se_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned IN_CHANNELS = 16,
    parameter int unsigned REDUCTION   = 4,
    parameter int unsigned IN_HEIGHT   = 56,
    parameter int unsigned IN_WIDTH    = 56,
    parameter int unsigned ATT_TIMEOUT = 4096,
    localparam int unsigned TOTAL      = calc_total(IN_HEIGHT, IN_WIDTH, IN_CHANNELS),
    localparam int unsigned AW         = $clog2(TOTAL)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  wt_valid,
    output logic                  wt_ready,
    output logic                  load_kernel_conv1,
    output logic                  load_kernel_conv2,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  dp_in_valid,
    output logic [AW-1:0]         buf_wr_addr,
    input  logic                  att_valid,
    input  logic [DATA_WIDTH-1:0] att_data,
    output logic                  buf_rd_en,
    output logic [AW-1:0]         buf_rd_addr,
    output logic                  scale_valid,
    output logic [DATA_WIDTH-1:0] scale_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout
);

    localparam int unsigned K1  = calc_k1(IN_CHANNELS, REDUCTION);
    localparam int unsigned K2  = K1;
    localparam int unsigned WCW = $clog2(K1 + 1);
    localparam int unsigned CW  = $clog2(TOTAL + 1);
    localparam int unsigned CHW = $clog2(IN_CHANNELS);
    localparam int unsigned ACW = $clog2(IN_CHANNELS + 1);
    localparam int unsigned TW  = $clog2(ATT_TIMEOUT + 1);

    if (IN_CHANNELS % REDUCTION != 0) begin : g_bad_reduction
        $error("IN_CHANNELS must be a multiple of REDUCTION");
    end

    se_state_t             state_q, state_d;
    logic [WCW-1:0]        wt_cnt_q, wt_cnt_d;
    logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
    logic [CHW-1:0]        rd_ch_q, rd_ch_d;
    logic [ACW-1:0]        att_ch_q, att_ch_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  scale_valid_q, scale_valid_d;
    logic [DATA_WIDTH-1:0] scale_data_q, scale_data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  advance;
    logic                  tbl_wr_en;
    logic [DATA_WIDTH-1:0] tbl_rd_data;

    se_scale_table #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IN_CHANNELS)
    ) u_scale_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tbl_wr_en),
        .wr_addr (CHW'(att_ch_q)),
        .wr_data (att_data),
        .rd_addr (rd_ch_q),
        .rd_data (tbl_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wt_cnt_q      <= '0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            rd_ch_q       <= '0;
            att_ch_q      <= '0;
            timer_q       <= '0;
            scale_valid_q <= 1'b0;
            scale_data_q  <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wt_cnt_q      <= wt_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            rd_ch_q       <= rd_ch_d;
            att_ch_q      <= att_ch_d;
            timer_q       <= timer_d;
            scale_valid_q <= scale_valid_d;
            scale_data_q  <= scale_data_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wt_cnt_d      = wt_cnt_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        rd_ch_d       = rd_ch_q;
        att_ch_d      = att_ch_q;
        timer_d       = timer_q;
        scale_valid_d = scale_valid_q;
        scale_data_d  = scale_data_q;
        done_d        = 1'b0;
        err_d         = err_q;
        wt_ready      = 1'b0;
        in_ready      = 1'b0;
        buf_rd_en     = 1'b0;
        tbl_wr_en     = 1'b0;
        advance       = !scale_valid_q || out_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD_W1;
                    wt_cnt_d = '0;
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
                    rd_ch_d  = '0;
                    att_ch_d = '0;
                    timer_d  = '0;
                    err_d    = 1'b0;
                end
            end
            LOAD_W1: begin
                wt_ready = 1'b1;
                if (wt_valid) begin
                    if (wt_cnt_q == WCW'(K1 - 1)) begin
                        wt_cnt_d = '0;
                        state_d  = LOAD_W2;
                    end else begin
                        wt_cnt_d = wt_cnt_q + 1'b1;
                    end
                end
            end
            LOAD_W2: begin
                wt_ready = 1'b1;
                if (wt_valid) begin
                    if (wt_cnt_q == WCW'(K2 - 1)) begin
                        wt_cnt_d = '0;
                        state_d  = SQUEEZE;
                    end else begin
                        wt_cnt_d = wt_cnt_q + 1'b1;
                    end
                end
            end
            SQUEEZE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == CW'(TOTAL - 1)) begin
                        state_d = WAIT_ATT;
                    end
                end
            end
            WAIT_ATT: begin
                timer_d = timer_q + 1'b1;
                if (att_valid) begin
                    tbl_wr_en = 1'b1;
                    att_ch_d  = att_ch_q + 1'b1;
                end
                // A capture completing in the last allowed cycle still wins
                if (att_valid && (att_ch_q == ACW'(IN_CHANNELS - 1))) begin
                    state_d = EXCITE;
                end else if (timer_q == TW'(ATT_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            EXCITE: begin
                if (advance) begin
                    if (rd_cnt_q != CW'(TOTAL)) begin
                        buf_rd_en     = 1'b1;
                        rd_cnt_d      = rd_cnt_q + 1'b1;
                        rd_ch_d       = (rd_ch_q == CHW'(IN_CHANNELS - 1)) ? '0 : rd_ch_q + 1'b1;
                        scale_valid_d = 1'b1;
                        scale_data_d  = tbl_rd_data;
                    end else begin
                        scale_valid_d = 1'b0;
                        scale_data_d  = '0;
                        if (scale_valid_q) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign load_kernel_conv1 = wt_valid && wt_ready && (state_q == LOAD_W1);
    assign load_kernel_conv2 = wt_valid && wt_ready && (state_q == LOAD_W2);
    assign dp_in_valid       = in_valid && in_ready;
    assign buf_wr_addr       = (state_q == SQUEEZE) ? AW'(wr_cnt_q) : '0;
    assign buf_rd_addr       = buf_rd_en ? AW'(rd_cnt_q) : '0;
    assign scale_valid       = scale_valid_q;
    assign scale_data        = scale_data_q;
    assign busy              = (state_q != IDLE);
    assign done              = done_q;
    assign err_timeout       = err_q;

endmodule

// File: doc/se_frame_sequencer.md
Name: se_frame_sequencer

Overview:
Frame-level controller for the squeeze-and-excitation datapath. Per frame it runs these phases in order:
- loads the conv1 and conv2 1x1 kernels;
- admits the input feature stream to the pool/buffer;
- captures one hard-sigmoid attention value per channel into a local scale table;
- replays the stored frame from the external input buffer, presenting the matching per-channel scale alongside each word.

It sits between the bottleneck-layer top and the SE datapath, and replaces the datapath's single-scale, self-timed output logic.

Parameters:
- DATA_WIDTH, 16, width of activation, weight and scale words (scale is Q8.8).
- IN_CHANNELS, 16, channels per pixel.
- REDUCTION, 4, channel reduction ratio; IN_CHANNELS % REDUCTION must be 0.
- IN_HEIGHT, 56, frame rows.
- IN_WIDTH, 56, frame columns.
- ATT_TIMEOUT, 4096, maximum cycles to wait for all attention values.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin frame; sampled only in IDLE
- wt_valid  in  1  weight word available (conv1 words first, then conv2)
- wt_ready  out  1  weight word accepted this cycle
- load_kernel_conv1  out  1  = wt_valid & wt_ready in LOAD_W1
- load_kernel_conv2  out  1  = wt_valid & wt_ready in LOAD_W2
- in_valid  in  1  upstream feature word valid
- in_ready  out  1  controller admits feature word
- dp_in_valid  out  1  = in_valid & in_ready, drives datapath input_valid and buffer write
- buf_wr_addr  out  $clog2(TOTAL)  buffer write address
- att_valid  in  1  hard-sigmoid output valid
- att_data  in  DATA_WIDTH  attention value, channel order 0..IN_CHANNELS-1
- buf_rd_en  out  1  buffer read strobe
- buf_rd_addr  out  $clog2(TOTAL)  buffer read address
- scale_valid  out  1  scale aligned with buffer read data
- scale_data  out  DATA_WIDTH  scale for the word currently on buffer output
- out_ready  in  1  downstream accepts the scaled word
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse at frame end
- err_timeout  out  1  sticky; cleared by start or reset

Behaviour:
- Clocking and reset. Single clock; reset is synchronous, active-low (rst_n sampled on posedge clk). All state updates on posedge clk.
- Derived constants:
  - K1 = IN_CHANNELS*IN_CHANNELS/REDUCTION
  - K2 = K1
  - TOTAL = IN_HEIGHT*IN_WIDTH*IN_CHANNELS
- Reset values:
  - state = IDLE; all outputs 0; err_timeout = 0.
  - Scale table entries = 16'h0100.
  - All counters = 0.
  - Reset mid-frame aborts immediately; no done pulse.
- IDLE:
  - wt_ready = in_ready = buf_rd_en = 0.
  - start=1: clear counters and err_timeout, go to LOAD_W1.
- LOAD_W1:
  - wt_ready = 1.
  - Count accepted words; on the K1-th accept go to LOAD_W2.
- LOAD_W2:
  - Same as LOAD_W1 with K2; then go to SQUEEZE.
- SQUEEZE:
  - in_ready = 1; buf_wr_addr = wr_cnt.
  - wr_cnt increments per accepted word.
  - Data is pixel-major, channel-fastest.
  - On the TOTAL-th accept go to WAIT_ATT.
- WAIT_ATT:
  - Each att_valid writes att_data to scale_table[att_ch], then att_ch++.
  - On the IN_CHANNELS-th capture go to EXCITE.
  - A timer counts cycles in this state. Reaching ATT_TIMEOUT sets err_timeout, forces done, and returns to IDLE; the table keeps partial contents.
  - att_valid outside WAIT_ATT is ignored, including any arriving during SQUEEZE.
- EXCITE (replay):
  - One-stage pipeline, 1-cycle buffer read latency.
  - advance = !scale_valid | out_ready.
  - buf_rd_en = advance & (rd_cnt < TOTAL); buf_rd_addr = rd_cnt.
  - Next cycle: scale_valid = 1 and scale_data = scale_table[rd_cnt_q % IN_CHANNELS], where rd_cnt_q is the read address registered alongside buf_rd_en.
  - While scale_valid & !out_ready, hold scale_valid and scale_data; buf_rd_en = 0. The buffer output register must hold when rd_en = 0.
  - Channel index is a wrap counter (0..IN_CHANNELS-1), not a divider.
  - After the final word is accepted (scale_valid & out_ready with rd_cnt == TOTAL): done = 1 for one cycle, go to IDLE.
- Other rules:
  - start outside IDLE is ignored.
  - busy = (state != IDLE).
  - Counter widths are $clog2(max+1); no wrap occurs within a frame.

Decomposition:
- Package se_pkg holds:
  - state enum se_state_t {IDLE, LOAD_W1, LOAD_W2, SQUEEZE, WAIT_ATT, EXCITE};
  - localparam function computing K1 and TOTAL;
  - the Q8.8 constant SCALE_ONE = 16'h0100.
- One sub-module, se_scale_table: IN_CHANNELS x DATA_WIDTH register file with one synchronous write, one combinational read, and reset to SCALE_ONE.

Test Plan:
Bench configuration: IN_CHANNELS=4, REDUCTION=2, IN_HEIGHT=IN_WIDTH=2 (TOTAL=16, K1=K2=8).
1. Nominal frame. start, 16 weights with wt_valid held high → load_kernel_conv1 high exactly cycles 1-8 after start, load_kernel_conv2 high cycles 9-16. Then 16 words, then att 0x0080, 0x0100, 0x0040, 0x00C0 → replay of 16 reads with scale_data cycling 0x0080, 0x0100, 0x0040, 0x00C0; done pulses once; busy falls the same cycle.
2. Backpressure. out_ready toggles 1,0,0,1 repeatedly → no read while stalled, scale_data stable during stalls, exactly 16 accepted words, addresses 0..15 in order.
3. Sparse input. in_valid on alternate cycles during SQUEEZE → buf_wr_addr 0..15 with no gaps; WAIT_ATT entered only after the 16th accept.
4. Attention timeout. ATT_TIMEOUT=32, supply only 2 att values → err_timeout=1 and done pulse at cycle 32 of WAIT_ATT, then IDLE. The next start clears err_timeout.
5. Reset mid-replay. Drive rst_n=0 at read 7 → next cycle all outputs 0, state IDLE, table reads 0x0100, no done pulse.
6. Stray controls. start pulsed during SQUEEZE and att_valid pulsed during LOAD_W2 → no state change, scale table unchanged.
